led_seq_ctrl: RTL

Sequencer that drives the board's 4 user LEDs with one of four selectable animation patterns, at a rate set by an internal prescaler. Sits between `top` and the LED pins. Accepts start/stop pulses and a valid/ready mode-select handshake from switch/button logic. Replaces free-running counter LED logic with a controllable state machine.

---
 rtl/led_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencer for the board's 4 user LEDs.
// Plays one of four animations (SHIFT, BOUNCE, COUNT, BLINK), advancing one
// step every TICK_DIV clocks. Controlled by start/stop pulses and a
// valid/ready mode-select handshake.
// Optional feature macro: LED_PWM_EN adds a 4-bit brightness input that
// dims the LEDs with a free-running 16-step PWM.
module led_seq_ctrl #(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic       mode_valid,
`ifdef LED_PWM_EN
    input  logic [3:0] brightness,
`endif
    output logic       mode_ready,
    output logic [3:0] led,
    output logic       busy,
    output logic       tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SHIFT  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       mode_reg;
    logic [CNT_W-1:0] div_cnt;
    logic             dir;
    logic [3:0]       pattern;
    logic [3:0]       pat_step;
    logic             dir_step;
    logic             xfer;
    logic             wrap;

    // Starting frame of each animation.
    function automatic logic [3:0] init_pattern(input logic [1:0] m);
        case (m)
            MODE_SHIFT:  init_pattern = 4'b0001;
            MODE_BOUNCE: init_pattern = 4'b0001;
            MODE_COUNT:  init_pattern = 4'b0000;
            default:     init_pattern = 4'b1111;
        endcase
    endfunction

    assign xfer = mode_valid && mode_ready;
    assign wrap = (div_cnt == DIV_LAST);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking (=) is reserved for combinational blocks.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a mode transfer outranks start/stop, and stop outranks start.
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path driven, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!xfer && start) state_nxt = LOAD;
            end
            LOAD: state_nxt = RUN;
            RUN: begin
                if (xfer)      state_nxt = LOAD;
                else if (stop) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (xfer)       state_nxt = LOAD;
                else if (stop)  state_nxt = IDLE;
                else if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        busy       = (state != IDLE);
        mode_ready = (state != LOAD);
    end

    // Compute the next animation frame (and bounce direction) from the current one.
    always_comb begin
        pat_step = pattern;
        dir_step = dir;
        case (mode_reg)
            MODE_SHIFT: pat_step = {pattern[2:0], pattern[3]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (pattern == 4'b1000) begin
                        pat_step = 4'b0100;
                        dir_step = DIR_RIGHT;
                    end else begin
                        pat_step = pattern << 1;
                    end
                end else begin
                    if (pattern == 4'b0001) begin
                        pat_step = 4'b0010;
                        dir_step = DIR_LEFT;
                    end else begin
                        pat_step = pattern >> 1;
                    end
                end
            end
            MODE_COUNT: pat_step = pattern + 4'd1;
            default:    pat_step = ~pattern;
        endcase
    end

    // Datapath: mode capture, prescaler, pattern register and step pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg <= MODE_SHIFT;
            div_cnt  <= '0;
            dir      <= DIR_LEFT;
            pattern  <= 4'b0000;
            tick     <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (xfer) mode_reg <= mode;
            case (state)
                IDLE: pattern <= 4'b0000;
                LOAD: begin
                    pattern <= init_pattern(mode_reg);
                    div_cnt <= '0;
                    dir     <= DIR_LEFT;
                end
                RUN: begin
                    if (wrap) begin
                        div_cnt <= '0;
                        pattern <= pat_step;
                        dir     <= dir_step;
                        tick    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    // Leaving for IDLE blanks the LEDs on the same edge.
                    if (state_nxt == IDLE) pattern <= 4'b0000;
                end
                default: pattern <= 4'b0000;
            endcase
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase counter for brightness control.
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 4'd0;
        else     pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign led = pattern & {4{pwm_cnt < brightness}};
`else
    assign led = pattern;
`endif

endmodule
